// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared constants for the seven-segment scan controller:
//   - SEG_A..SEG_G : bit positions of each segment on the seg bus (seg[0]=a).
//   - SEG_OFF      : all segments dark (active-high sense).
//   - GLYPH_TABLE  : 16 hex glyphs, entry n written as 7'bgfedcba, active-high.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_OFF = 7'b000_0000;

    // Entry [0] is the LSB group, so the list runs F down to 0.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if
//   Display-content bus from the board glue (master) to the scan
//   controller (slave).
//   - digits : 4*NUM_DIGITS hex nibbles, digit 0 in bits [3:0] (rightmost)
//   - dp_in  : decimal-point request per digit
//   - blank  : force digit dark, dp included
//   - lz_en  : leading-zero suppression enable
//   - bright : duty level, 0 = 1/16 .. 15 = 16/16
//   - en     : 0 = all anodes inactive
//   There is no valid/ready pair: every field is a level. digits, dp_in,
//   blank and lz_en are sampled together at the start of each frame;
//   bright and en are sampled every cycle.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    lz_en;
    logic [3:0]              bright;
    logic                    en;

    modport master (output digits, dp_in, blank, lz_en, bright, en);
    modport slave  (input  digits, dp_in, blank, lz_en, bright, en);
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode
//   Purely combinational hex-to-seven-segment decoder.
//   - hex : 4-bit value 0..F
//   - seg : active-high segments, seg[0]=a .. seg[6]=g
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    logic [6:0] glyph;

    // Table notation is fixed gfedcba; map through the named bit positions
    // so the bus order can change without touching the table.
    always_comb begin
        glyph      = GLYPH_TABLE[hex];
        seg        = SEG_OFF;
        seg[SEG_A] = glyph[0];
        seg[SEG_B] = glyph[1];
        seg[SEG_C] = glyph[2];
        seg[SEG_D] = glyph[3];
        seg[SEG_E] = glyph[4];
        seg[SEG_F] = glyph[5];
        seg[SEG_G] = glyph[6];
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexes NUM_DIGITS hex digits onto one segment bus with
//   per-digit anodes, 16-level PWM brightness, leading-zero suppression,
//   per-digit blanking and a per-frame content snapshot.
//   - clk, rst_n : clock, asynchronous active-low reset
//   - disp       : content bus (seg7_scan_ctrl_if.slave)
//   - seg        : segments, seg[0]=a .. seg[6]=g
//   - an         : anode selects, one per digit
//   - dp         : decimal point
//   - frame_tick : one-cycle pulse in the first cycle showing a new snapshot
//   Output polarity is set by ACTIVE_LOW (1 = Basys-style active-low).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SUB_DIV    = 195,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_scan_ctrl_if.slave       disp,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  dp,
    output logic                  frame_tick
);

    localparam int   IDX_W = $clog2(NUM_DIGITS);
    localparam int   SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam logic POL   = (ACTIVE_LOW != 0);

    // Scan counters
    logic [SUB_W-1:0] sub_cnt;
    logic [3:0]       phase;
    logic [IDX_W-1:0] idx;
    logic             load_pending;

    // Frame snapshot
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic                    snap_lz;

    // Registered outputs, active-high internally
    logic [6:0]            seg_r;
    logic [NUM_DIGITS-1:0] an_r;
    logic                  dp_r;
    logic                  tick_r;

    logic                    load;
    logic                    sub_last;
    logic [4*NUM_DIGITS-1:0] view_digits;
    logic [NUM_DIGITS-1:0]   view_dp;
    logic [NUM_DIGITS-1:0]   view_blank;
    logic                    view_lz;
    logic [IDX_W+1:0]        nib_base;
    logic [3:0]              cur_hex;
    logic [6:0]              glyph;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    zero_above;
    logic                    suppressed;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;
    logic                    dp_next;

    // The snapshot reloads in the cycle the counters sit at the start of a
    // frame. That cycle's output is computed from the incoming values, so
    // the first slot of a frame already shows the new content.
    assign load     = load_pending || ((idx == '0) && (phase == 4'd0) && (sub_cnt == '0));
    assign sub_last = (sub_cnt == SUB_W'(SUB_DIV - 1));

    assign view_digits = load ? disp.digits : snap_digits;
    assign view_dp     = load ? disp.dp_in  : snap_dp;
    assign view_blank  = load ? disp.blank  : snap_blank;
    assign view_lz     = load ? disp.lz_en  : snap_lz;

    assign nib_base = {idx, 2'b00};
    assign cur_hex  = view_digits[nib_base +: 4];

    seg7_hex_decode u_dec (
        .hex (cur_hex),
        .seg (glyph)
    );

    // lz_mask[i] = every digit from i up to the top is zero.
    always_comb begin
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (view_digits[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_above;
        end
    end

    // Digit 0 is never suppressed so an all-zero value still reads "0".
    assign suppressed = view_lz && (idx != '0) && lz_mask[idx];

    // Blanked digits keep their anode off entirely; suppressed digits keep
    // the anode on so their decimal point can still show.
    assign lit = disp.en && (phase <= disp.bright) && !view_blank[idx];

    always_comb begin
        an_next  = '0;
        seg_next = SEG_OFF;
        dp_next  = 1'b0;
        if (lit) begin
            an_next[idx] = 1'b1;
            seg_next     = suppressed ? SEG_OFF : glyph;
            dp_next      = view_dp[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_cnt      <= '0;
            phase        <= 4'd0;
            idx          <= '0;
            load_pending <= 1'b1;
            snap_digits  <= '0;
            snap_dp      <= '0;
            snap_blank   <= '0;
            snap_lz      <= 1'b0;
            seg_r        <= SEG_OFF;
            an_r         <= '0;
            dp_r         <= 1'b0;
            tick_r       <= 1'b0;
        end else begin
            if (sub_last) begin
                sub_cnt <= '0;
                phase   <= phase + 4'd1;
                if (phase == 4'd15) begin
                    idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
                end
            end else begin
                sub_cnt <= sub_cnt + 1'b1;
            end

            if (load) begin
                snap_digits  <= disp.digits;
                snap_dp      <= disp.dp_in;
                snap_blank   <= disp.blank;
                snap_lz      <= disp.lz_en;
                load_pending <= 1'b0;
            end
            tick_r <= load;

            seg_r <= seg_next;
            an_r  <= an_next;
            dp_r  <= dp_next;
        end
    end

    // Polarity flip sits after the flops so reset drives the pins dark
    // immediately, independent of the clock.
    assign seg        = seg_r ^ {7{POL}};
    assign an         = an_r ^ {NUM_DIGITS{POL}};
    assign dp         = dp_r ^ POL;
    assign frame_tick = tick_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    localparam int N      = 4;
    localparam int SUBDIV = 2;
    localparam int SLOT   = 16 * SUBDIV;
    localparam int FRAME  = N * SLOT;

    // Active-low pin patterns, written 7'bgfedcba.
    localparam logic [6:0] P_0   = 7'h40;
    localparam logic [6:0] P_1   = 7'h79;
    localparam logic [6:0] P_2   = 7'h24;
    localparam logic [6:0] P_3   = 7'h30;
    localparam logic [6:0] P_4   = 7'h19;
    localparam logic [6:0] P_5   = 7'h12;
    localparam logic [6:0] P_A   = 7'h08;
    localparam logic [6:0] P_B   = 7'h03;
    localparam logic [6:0] P_C   = 7'h46;
    localparam logic [6:0] P_D   = 7'h21;
    localparam logic [6:0] P_OFF = 7'h7F;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp_in;
        logic [3:0]  blank;
        logic        lz_en;
        logic [3:0]  bright;
        logic        en;
        logic        mid_en;      // change digits at t=40 of the frame
        logic [15:0] mid_digits;
        logic [27:0] exp_seg;     // pin pattern when lit, digit i at [7i+6:7i]
        logic [3:0]  exp_dp;      // dp lit when the anode is on
        logic [3:0]  exp_lit;     // anode ever turns on in its slot
        logic [5:0]  exp_on;      // active cycles per lit slot
    } row_t;

    logic clk;
    logic rst_n;
    logic [6:0]   seg;
    logic [N-1:0] an;
    logic         dp;
    logic         frame_tick;

    seg7_scan_ctrl_if #(.NUM_DIGITS(N)) disp_if ();

    seg7_scan_ctrl #(
        .NUM_DIGITS (N),
        .SUB_DIV    (SUBDIV),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp       (disp_if),
        .seg        (seg),
        .an         (an),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [12:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    row_t rows[6];

    task automatic check_pins(input string name, input int t,
                              input logic [3:0] e_an, input logic [6:0] e_seg,
                              input logic e_dp, input logic e_tick);
        logic [12:0] e;
        exp_q.push_back({e_an, e_seg, e_dp, e_tick});
        e = exp_q.pop_front();
        n_cmp++;
        if ({an, seg, dp, frame_tick} !== e) begin
            n_fail++;
            $display("FAIL %s t=%0d: got an=%b seg=%b dp=%b tick=%b, want an=%b seg=%b dp=%b tick=%b",
                     name, t, an, seg, dp, frame_tick, e[12:9], e[8:2], e[1], e[0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // ---------------- driver tasks ----------------
    function automatic row_t mk_row(input logic [15:0] d, input logic [3:0] dpi,
                                    input logic [3:0] bl, input logic lz,
                                    input logic [3:0] br, input logic e,
                                    input logic men, input logic [15:0] md,
                                    input logic [27:0] es, input logic [3:0] ed,
                                    input logic [3:0] el, input logic [5:0] eo);
        row_t r;
        r.digits = d;  r.dp_in = dpi; r.blank = bl; r.lz_en = lz;
        r.bright = br; r.en = e; r.mid_en = men; r.mid_digits = md;
        r.exp_seg = es; r.exp_dp = ed; r.exp_lit = el; r.exp_on = eo;
        return r;
    endfunction

    task automatic apply_row(input row_t r);
        disp_if.digits = r.digits;
        disp_if.dp_in  = r.dp_in;
        disp_if.blank  = r.blank;
        disp_if.lz_en  = r.lz_en;
        disp_if.bright = r.bright;
        disp_if.en     = r.en;
    endtask

    // Returns on the negedge where frame_tick is seen; waited = negedges taken.
    task automatic wait_frame(output int waited);
        waited = 0;
        for (int k = 1; k <= 3 * FRAME; k++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                waited = k;
                break;
            end
        end
        if (waited == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_tick_timeout: got no tick in %0d cycles, want one", 3 * FRAME);
        end
    endtask

    // Starts on the frame_tick negedge (t=0) and checks every cycle of the frame.
    task automatic walk_frame(input row_t r, input string name);
        int d_idx;
        int ph;
        int on_cnt;
        logic lit;
        logic [3:0] sel;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        on_cnt = 0;
        for (int t = 0; t < FRAME; t++) begin
            if (t > 0) @(negedge clk);
            d_idx = t / SLOT;
            ph    = (t % SLOT) / SUBDIV;
            lit   = r.exp_lit[d_idx] && (ph <= int'(r.bright));
            sel   = 4'b0001 << d_idx;
            e_an  = lit ? ~sel : 4'hF;
            e_seg = lit ? r.exp_seg[7*d_idx +: 7] : P_OFF;
            check_pins(name, t, e_an, e_seg, !(lit && r.exp_dp[d_idx]), (t == 0));
            if (an[d_idx] === 1'b0) on_cnt++;
            if ((t % SLOT) == SLOT - 1) begin
                check_int({name, "_on_cycles"}, on_cnt, r.exp_lit[d_idx] ? int'(r.exp_on) : 0);
                on_cnt = 0;
            end
            if (r.mid_en && t == 40) disp_if.digits = r.mid_digits;
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int waited;

        //                 digits    dp_in    blank    lz    bright en  mid   mid_digits
        //                 exp_seg (digit3..digit0)       exp_dp   exp_lit  on
        rows[0] = mk_row(16'h1234, 4'b0000, 4'b0000, 1'b0, 4'd15, 1'b1, 1'b1, 16'hABCD,
                         {P_1, P_2, P_3, P_4},           4'b0000, 4'b1111, 6'd32);
        rows[1] = mk_row(16'hABCD, 4'b0000, 4'b0000, 1'b0, 4'd3,  1'b1, 1'b0, 16'h0000,
                         {P_A, P_B, P_C, P_D},           4'b0000, 4'b1111, 6'd8);
        rows[2] = mk_row(16'h0050, 4'b1000, 4'b0000, 1'b1, 4'd0,  1'b1, 1'b0, 16'h0000,
                         {P_OFF, P_OFF, P_5, P_0},       4'b1000, 4'b1111, 6'd2);
        rows[3] = mk_row(16'h0000, 4'b0000, 4'b0000, 1'b1, 4'd15, 1'b1, 1'b0, 16'h0000,
                         {P_OFF, P_OFF, P_OFF, P_0},     4'b0000, 4'b1111, 6'd32);
        rows[4] = mk_row(16'h1234, 4'b0010, 4'b0010, 1'b0, 4'd15, 1'b1, 1'b0, 16'h0000,
                         {P_1, P_2, P_OFF, P_4},         4'b0000, 4'b1101, 6'd32);
        rows[5] = mk_row(16'h1234, 4'b0000, 4'b0000, 1'b0, 4'd15, 1'b0, 1'b0, 16'h0000,
                         {P_1, P_2, P_3, P_4},           4'b0000, 4'b0000, 6'd32);

        rst_n = 1'b0;
        apply_row(rows[0]);
        repeat (3) @(negedge clk);
        check_pins("reset", 0, 4'hF, P_OFF, 1'b1, 1'b0);

        // First frame right after release, with a mid-frame content change.
        rst_n = 1'b1;
        wait_frame(waited);
        check_int("first_tick_latency", waited, 1);
        walk_frame(rows[0], "first_frame");

        for (int i = 1; i < 6; i++) begin
            apply_row(rows[i]);
            wait_frame(waited);
            check_int($sformatf("row%0d_frame_period", i), waited, 1);
            walk_frame(rows[i], $sformatf("row%0d", i));
        end

        // Asynchronous reset in the middle of slot 2.
        apply_row(rows[0]);
        wait_frame(waited);
        check_int("pre_reset_frame_period", waited, 1);
        repeat (70) @(negedge clk);
        check_pins("pre_reset_lit", 70, 4'b1011, P_2, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_pins("async_reset", 70, 4'hF, P_OFF, 1'b1, 1'b0);
        disp_if.digits = 16'h5000;
        repeat (2) @(negedge clk);
        check_pins("reset_held", 0, 4'hF, P_OFF, 1'b1, 1'b0);
        rst_n = 1'b1;
        wait_frame(waited);
        check_int("post_reset_tick_latency", waited, 1);
        check_pins("post_reset_snapshot", 0, 4'b1110, P_0, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
